// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults for the FIFO controller.
package fifo_pkg;
   localparam int ADDRESS_SIZE_D = 2;
   localparam int MEMORY_DEPTH_D = 4;
   localparam int AF_LEVEL_D     = 3;
   localparam int PTR_W_D        = ADDRESS_SIZE_D + 1;
endpackage

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: producer/consumer requests and memory-side controls of the FIFO controller.
interface fifo_ctrl_if import fifo_pkg::*; #(parameter int ADDRESS_SIZE = ADDRESS_SIZE_D);
   logic                  wr_en, rd_en, cw_en, cr_en, rvalid;
   logic                  full, empty, almost_full, overflow, underflow;
   logic [ADDRESS_SIZE-1:0] w_ptr, r_ptr;
   logic [ADDRESS_SIZE:0]   count;
   modport master (output wr_en, rd_en,
                   input cw_en, cr_en, w_ptr, r_ptr, rvalid, full, empty, almost_full, count, overflow, underflow);
   modport slave  (input wr_en, rd_en,
                   output cw_en, cr_en, w_ptr, r_ptr, rvalid, full, empty, almost_full, count, overflow, underflow);
endinterface

// File: rtl/fifo_ptr_cnt.sv
// fifo_ptr_cnt: wrapping pointer counter that advances on inc.
module fifo_ptr_cnt #(parameter int W = fifo_pkg::PTR_W_D) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] ptr
);
   always_ff @(posedge clk)
      if (rst) ptr <= '0;
      else if (inc) ptr <= ptr + 1'b1;
endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and status control for a synchronous FIFO around a registered-read memory.
module fifo_ctrl import fifo_pkg::*; #(
   parameter int ADDRESS_SIZE = ADDRESS_SIZE_D,
   parameter int MEMORY_DEPTH = MEMORY_DEPTH_D,
   parameter int AF_LEVEL     = AF_LEVEL_D
) (
   input logic        clk,
   input logic        rst,
   fifo_ctrl_if.slave bus
);
   localparam int PW = $clog2(MEMORY_DEPTH) + 1;
   logic [PW-1:0] wp, rp, cnt;
   logic full, empty, cw, cr, rvalid_q, ovf_q, unf_q;
   // Status comes only from registered pointers, so a request never affects its own qualification.
   assign empty = wp == rp;
   assign full  = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
   assign cnt   = wp - rp;
   assign cw    = bus.wr_en & ~full & ~rst;
   assign cr    = bus.rd_en & ~empty & ~rst;
   fifo_ptr_cnt #(.W(PW)) u_wr (.clk(clk), .rst(rst), .inc(cw), .ptr(wp));
   fifo_ptr_cnt #(.W(PW)) u_rd (.clk(clk), .rst(rst), .inc(cr), .ptr(rp));
   always_ff @(posedge clk)
      if (rst) begin
         rvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         rvalid_q <= cr;
         ovf_q    <= bus.wr_en & full;
         unf_q    <= bus.rd_en & empty;
      end
   assign bus.cw_en       = cw;
   assign bus.cr_en       = cr;
   assign bus.w_ptr       = wp[PW-2:0];
   assign bus.r_ptr       = rp[PW-2:0];
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.count       = cnt;
   assign bus.almost_full = cnt >= PW'(AF_LEVEL);
   assign bus.rvalid      = rvalid_q;
   assign bus.overflow    = ovf_q;
   assign bus.underflow   = unf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed vectors with a queue-based scoreboard for fifo_ctrl at depth 4.
module tb_fifo_ctrl;
   import fifo_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   fifo_ctrl_if #(.ADDRESS_SIZE(2)) bus ();
   fifo_ctrl #(.ADDRESS_SIZE(2), .MEMORY_DEPTH(4), .AF_LEVEL(3)) dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct { logic cw, cr; } comb_t;
   typedef struct { int wp, rp, cnt; logic f, e, af, rv, ov, un; } st_t;
   comb_t cq[$];
   st_t   sq[$];
   int n_cmp = 0, n_bad = 0;
   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask
   task automatic step(logic r, w, rd, cw, cr, int wp, rp, cnt, logic f, e, af, rv, ov, un);
      @(negedge clk);
      #1;
      rst = r;
      bus.wr_en = w;
      bus.rd_en = rd;
      cq.push_back('{cw, cr});
      sq.push_back('{wp, rp, cnt, f, e, af, rv, ov, un});
   endtask
   // State expectations describe the outputs after the edge that consumes the vector.
   initial forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
         st_t s;
         s = sq.pop_front();
         chk("w_ptr", int'(bus.w_ptr), s.wp);
         chk("r_ptr", int'(bus.r_ptr), s.rp);
         chk("count", int'(bus.count), s.cnt);
         chk("full", int'(bus.full), int'(s.f));
         chk("empty", int'(bus.empty), int'(s.e));
         chk("almost_full", int'(bus.almost_full), int'(s.af));
         chk("rvalid", int'(bus.rvalid), int'(s.rv));
         chk("overflow", int'(bus.overflow), int'(s.ov));
         chk("underflow", int'(bus.underflow), int'(s.un));
      end
      #3;
      if (cq.size() > 0) begin
         comb_t c;
         c = cq.pop_front();
         chk("cw_en", int'(bus.cw_en), int'(c.cw));
         chk("cr_en", int'(bus.cr_en), int'(c.cr));
      end
   end
   initial begin
      int guard;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      //   rst wr rd cw cr  wp rp cnt f  e  af rv ov un
      step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 2, 0, 2, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 3, 0, 3, 0, 0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 4, 1, 0, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0);
      step(0, 1, 1, 0, 1, 0, 1, 3, 0, 0, 1, 1, 1, 0);
      step(0, 0, 1, 0, 1, 0, 2, 2, 0, 0, 0, 1, 0, 0);
      step(0, 1, 1, 1, 1, 1, 3, 2, 0, 0, 0, 1, 0, 0);
      step(0, 1, 1, 1, 1, 2, 0, 2, 0, 0, 0, 1, 0, 0);
      step(0, 1, 1, 1, 1, 3, 1, 2, 0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1, 3, 2, 1, 0, 0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 1, 3, 3, 0, 0, 1, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0, 3, 3, 0, 0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 3, 3, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 1, 0, 1, 3, 2, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 2, 3, 3, 0, 0, 1, 0, 0, 0);
      step(0, 0, 1, 0, 1, 2, 0, 2, 0, 0, 0, 1, 0, 0);
      step(1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      guard = 0;
      while ((sq.size() > 0 || cq.size() > 0) && guard < 10) begin
         @(negedge clk);
         #2;
         guard++;
      end
      chk("drain", sq.size() + cq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have the parameter ADDRESS_SIZE, default 2, meaning the memory address width.
REQ-002 The block SHALL have the parameter MEMORY_DEPTH, default 4, meaning the entry count; it SHALL equal 2**ADDRESS_SIZE.
REQ-003 The block SHALL have the parameter AF_LEVEL, default 3, meaning the almost_full threshold in entries.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, as listed in REQ-005 and REQ-006.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  1  producer write request.
REQ-008 rd_en  in  1  consumer read request.
REQ-009 cw_en  out  1  qualified write enable to the memory.
REQ-010 cr_en  out  1  qualified read enable to the memory.
REQ-011 w_ptr  out  ADDRESS_SIZE  memory write address.
REQ-012 r_ptr  out  ADDRESS_SIZE  memory read address.
REQ-013 rvalid  out  1  memory rdata is valid this cycle.
REQ-014 full  out  1  FIFO holds MEMORY_DEPTH entries.
REQ-015 empty  out  1  FIFO holds 0 entries.
REQ-016 almost_full  out  1  count >= AF_LEVEL.
REQ-017 count  out  ADDRESS_SIZE+1  current occupancy, 0..MEMORY_DEPTH.
REQ-018 overflow  out  1  one-cycle pulse: a write was rejected.
REQ-019 underflow  out  1  one-cycle pulse: a read was rejected.

Function
REQ-020 cw_en SHALL be combinational: wr_en & !full & !rst.
REQ-021 cr_en SHALL be combinational: rd_en & !empty & !rst.
REQ-022 full SHALL be evaluated against current state, so a write when full is rejected even if a read is accepted in the same cycle.
REQ-023 empty SHALL be evaluated against current state, so a read when empty is rejected even if a write is accepted in the same cycle.
REQ-024 w_ptr SHALL increment by 1 modulo MEMORY_DEPTH on each cycle with cw_en=1.
REQ-025 r_ptr SHALL increment by 1 modulo MEMORY_DEPTH on each cycle with cr_en=1.
REQ-026 Internal pointers SHALL be ADDRESS_SIZE+1 bits wide; w_ptr and r_ptr SHALL be their low ADDRESS_SIZE bits.
REQ-027 empty SHALL be asserted when the internal pointers are equal.
REQ-028 full SHALL be asserted when the internal pointer MSBs differ and the low bits are equal.
REQ-029 count SHALL equal the internal write pointer minus the internal read pointer, modulo 2**(ADDRESS_SIZE+1); it is unchanged when cw_en and cr_en are both 1.
REQ-030 full, empty, almost_full and count SHALL be registered state or derived from registered pointers only, never from wr_en or rd_en.
REQ-031 rvalid SHALL be registered: rvalid=1 in cycle N+1 if and only if cr_en=1 in cycle N, aligning with the memory's one-cycle registered read.
REQ-032 overflow SHALL be 1 in cycle N+1 if and only if wr_en=1 and full=1 in cycle N.
REQ-033 underflow SHALL be 1 in cycle N+1 if and only if rd_en=1 and empty=1 in cycle N.
REQ-034 A rejected request SHALL change no pointer and no count.

Reset
REQ-035 When rst=1 at a clock edge, the pointers and count SHALL become 0, empty=1, full=0, almost_full=0, rvalid=0, overflow=0 and underflow=0.
REQ-036 rst SHALL dominate wr_en and rd_en in the same cycle, and cw_en and cr_en SHALL be 0 while rst=1.
REQ-037 A reset mid-operation SHALL discard all held entries, with no rvalid pulse in the following cycle.

Structure
REQ-038 A shared package fifo_pkg SHALL hold the default ADDRESS_SIZE, MEMORY_DEPTH, AF_LEVEL and the pointer-width constant ADDRESS_SIZE+1.
REQ-039 One sub-module, fifo_ptr_cnt, SHALL be instantiated twice: a wrapping (ADDRESS_SIZE+1)-bit counter with ports clk, rst, inc and ptr.
REQ-040 Pairing fifo_ctrl with the existing memory block SHALL form a complete synchronous FIFO without glue logic.

Verification (depth 4)
REQ-041 Reset then 4 writes -> w_ptr 0,1,2,3,0; count 1..4; almost_full from count=3; full=1 after the 4th write; empty=0 after the 1st write.
REQ-042 Full FIFO, wr_en=1 for 1 cycle -> cw_en=0, overflow pulses once, pointers and count unchanged.
REQ-043 Empty FIFO, rd_en=1 -> cr_en=0, underflow pulses next cycle, rvalid stays 0.
REQ-044 count=2, wr_en=rd_en=1 for 3 cycles -> count stays 2, both pointers advance 3 modulo 4, rvalid=1 in each following cycle.
REQ-045 Full FIFO, wr_en=rd_en=1 -> write rejected, read accepted, count 4->3, overflow=1; empty FIFO with both -> write accepted, read rejected, count 0->1, underflow=1.
REQ-046 count=3 with cr_en=1, rst=1 in the next cycle -> all outputs at reset values, rvalid=0 after the reset edge, cw_en=cr_en=0 during reset.
